// File: rtl/hash_apb_m01_pkg.sv
// Shared APB bus widths, requester FSM state encodings and watchdog sizing helper.
// Constants only; no logic.
// Imported by hash_apb_m01 and hash_apb_tmo.
package hash_apb_m01_pkg;

    localparam int CFG_ADDR_WIDTH   = 32;
    localparam int CFG_DATA_WIDTH   = 32;
    localparam int CFG_STROBE_WIDTH = CFG_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A disabled watchdog (0 cycles) still needs a legal 1-bit counter.
    function automatic int tmo_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hash_apb_tmo.sv
// Watchdog down-counter: loaded at transfer setup, decremented once per wait cycle.
// Latency: expired is combinational from the counter during the last allowed cycle.
// Backpressure: none; follows the requester FSM strobes.
module hash_apb_tmo #(
    parameter int WIDTH = 9
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    // Count of 1 marks the final permitted wait cycle.
    assign expired = en && (cnt == WIDTH'(1));

endmodule

// File: rtl/hash_apb_m01.sv
// APB4 requester: one SETUP/ACCESS transfer per accepted command, one-cycle response pulse.
// Latency: accept at T, SETUP T+1, ACCESS T+2, rsp_valid at T+3 plus wait states.
// Backpressure: cmd_ready only in IDLE; responses cannot be stalled.
module hash_apb_m01
    import hash_apb_m01_pkg::*;
#(
    parameter int APB_ADDR_WIDTH   = CFG_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH   = CFG_DATA_WIDTH,
    parameter int APB_STROBE_WIDTH = CFG_STROBE_WIDTH,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [APB_STROBE_WIDTH-1:0] cmd_strb,
    input  logic [2:0]                  cmd_prot,
    output logic                        rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic                        PWRITE,
    output logic [APB_DATA_WIDTH-1:0]   PWDATA,
    output logic [APB_STROBE_WIDTH-1:0] PSTRB,
    output logic [2:0]                  PPROT,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic [APB_DATA_WIDTH-1:0]   PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

    logic [1:0] state;
    logic       tmo_expired;

    // Decoded from the state register so reset drops PSEL/PENABLE without a clock edge.
    assign cmd_ready = (state == ST_IDLE);
    assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE   = (state == ST_ACCESS);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            hash_apb_tmo #(
                .WIDTH (TMO_W)
            ) u_tmo (
                .core_clk (PCLK),
                .arst_n   (PRESETn),
                .clr      (state == ST_IDLE),
                .load     (state == ST_SETUP),
                .en       (state == ST_ACCESS),
                .load_val (TMO_W'(TIMEOUT_CYCLES)),
                .expired  (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state  <= ST_SETUP;
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_write ? cmd_wdata : '0;
                        PSTRB  <= cmd_write ? cmd_strb : '0;
                        PPROT  <= cmd_prot;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A PREADY in the watchdog's last cycle still completes normally.
                    if (PREADY) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    end else if (tmo_expired) begin
                        state       <= ST_IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
